hash_verifier: RTL and testbench
================================

# hash_verifier

Receiving-end checker for the 16-bit time/ID hasher stream. It accepts (time, hash) tokens over a valid/ready handshake and recomputes the expected hash with its own copy of the hasher recurrence. It reports pass/fail per token, counts failures, and locks out after too many consecutive mismatches. It sits downstream of `hasher` and consumes the tokens that block produces.

## Interface
- `MAX_FAIL`, default 3: consecutive mismatches that force LOCKED (legal range 1..15).
- `CNT_W`, default 8: width of the saturating total-failure counter.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `student_id` in 16: hash key, sampled with each accepted token.
- `in_valid` in 1: token present.
- `in_time` in 16: time value of the token.
- `in_hash` in 16: hash claimed by the sender.
- `in_ready` out 1: block can accept a token this cycle.
- `unlock` in 1: single-cycle request to leave LOCKED.
- `res_valid` out 1: one-cycle pulse; a result is present.
- `res_ok` out 1: result is a match; qualified by `res_valid`.
- `expected_hash` out 16: last computed expected hash, held between results.
- `fail_count` out CNT_W: total mismatches, saturating.
- `locked` out 1: high while in LOCKED.

## Operation
- Recurrence, all 16-bit with wrap-around and no carry-out: `e = rotl3((h ^ t) + id)`.
  - `h` is the chain register. `t` and `id` are the captured time and student ID.
  - `rotl3(x) = {x[12:0], x[15:13]}`.
- Reset values:
  - `h` = 0, `expected_hash` = 0, consecutive-fail counter = 0, `fail_count` = 0.
  - `res_valid` = 0, `res_ok` = 0, `locked` = 0, state = IDLE.
  - `in_ready` = 1.
- `in_ready` is high only in IDLE, derived combinationally from state.
- States:
  - IDLE: on `in_valid & in_ready`, capture `in_time`, `in_hash` and `student_id`, then go to CHECK.
  - CHECK (exactly one cycle): compute `e` and compare it with the captured hash.
    - Match: `h <= e`; consecutive-fail counter cleared; `res_ok <= 1`.
    - Mismatch: `h` unchanged; consecutive-fail counter +1; `fail_count` +1, saturating at `2**CNT_W-1`; `res_ok <= 0`.
    - Either case: `expected_hash <= e`; `res_valid <= 1`.
    - Next state is LOCKED if the incremented consecutive count equals `MAX_FAIL`, otherwise IDLE.
  - LOCKED: `in_ready` = 0 and `locked` = 1.
    - On `unlock`: `h` = 0, consecutive-fail counter = 0, go to IDLE.
    - `fail_count` and `expected_hash` are preserved through unlock.
- `unlock` is ignored in IDLE and CHECK.
- `in_valid` while `in_ready` = 0 is ignored; the sender must hold the token until a handshake.
- Captured registers must not follow input changes after the capture edge.

## Timing
- Handshake at edge k.
- `res_valid`, `res_ok` and `expected_hash` update at edge k+1. `res_valid` deasserts at edge k+2.
- `in_ready` rises again after edge k+1 unless the block enters LOCKED.
- Earliest next acceptance is edge k+2, so maximum throughput is 1 token per 2 cycles.
- On entry to LOCKED, `locked` rises at edge k+1, the same edge as the failing `res_valid`.
- `unlock` sampled at edge m in LOCKED: `in_ready` is high after edge m.
- `rst_n` low at any time, including mid-CHECK: every output immediately takes its reset value. No result pulse is emitted for the aborted token.

## Test plan
- Reset, then `id`=3, token (t=1, hash=32): at k+1 `res_valid`=1, `res_ok`=1, `expected_hash`=32. Then token (t=2, hash=296): `res_ok`=1, `expected_hash`=296.
- Wrap and rotate: `id`=0xFFFF, token (t=1, hash=0) gives `res_ok`=1. After reset, `id`=0, token (t=0xE000, hash=0x0007) gives `res_ok`=1.
- Mismatch keeps the chain:
  - `id`=3, token (t=1, hash=5): `res_ok`=0, `fail_count`=1, `expected_hash`=32.
  - Then token (t=1, hash=32): `res_ok`=1, consecutive counter cleared.
- Lockout with `MAX_FAIL`=3:
  - Three bad tokens give `locked`=1 at the third result and `in_ready`=0; `in_valid` held high is not accepted.
  - `unlock` pulse: `in_ready`=1; next token (t=1, hash=32, `id`=3) passes with `h` restarted from 0; `fail_count` stays 3.
- Back-to-back and held inputs:
  - `in_valid` held high with changing data: acceptances are exactly every 2 cycles.
  - `in_time` changed during CHECK does not alter the result.
- Async reset: assert `rst_n`=0 mid-CHECK.
  - No `res_valid` pulse; all outputs return to their reset values without waiting for a clock edge.
  - After release, the `id`=3, (t=1, hash=32) check passes.

Source files
------------

// File: rtl/hash_verifier.sv
// hash_verifier
//   Receiving-end checker for the 16-bit time/ID hasher stream. Each accepted
//   (time, hash) token is re-hashed with a local copy of the recurrence
//   e = rotl3((h ^ t) + id), compared against the claimed hash and reported.
//   After MAX_FAIL consecutive mismatches the block locks until unlock.
//
// Ports
//   clk, rst_n           : clock, asynchronous active-low reset
//   student_id [15:0]    : hash key, captured with each accepted token
//   in_valid/in_ready    : token handshake (ready only while idle)
//   in_time, in_hash     : token payload
//   unlock               : one-cycle request to leave the locked state
//   res_valid, res_ok    : one-cycle result pulse and match flag
//   expected_hash [15:0] : last computed expected hash (held)
//   fail_count [CNT_W-1:0]: saturating total mismatch count
//   locked               : high while locked out
module hash_verifier #(
  parameter int MAX_FAIL = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      student_id,
  input  logic             in_valid,
  input  logic [15:0]      in_time,
  input  logic [15:0]      in_hash,
  output logic             in_ready,
  input  logic             unlock,
  output logic             res_valid,
  output logic             res_ok,
  output logic [15:0]      expected_hash,
  output logic [CNT_W-1:0] fail_count,
  output logic             locked
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] MAX_FAIL_C = 4'(MAX_FAIL);

  state_t             state_q, state_d;
  logic [15:0]        h_q, h_d;
  logic [15:0]        t_q, t_d;
  logic [15:0]        hash_q, hash_d;
  logic [15:0]        id_q, id_d;
  logic [15:0]        exp_q, exp_d;
  logic [3:0]         cfail_q, cfail_d;
  logic [CNT_W-1:0]   fail_q, fail_d;
  logic               res_valid_q, res_valid_d;
  logic               res_ok_q, res_ok_d;

  logic [15:0]        sum;
  logic [15:0]        e_val;
  logic [3:0]         cfail_inc;

  // Recurrence datapath from the captured token.
  assign sum = (h_q ^ t_q) + id_q;

  // Rotate left by 3: output bit gi takes input bit (gi - 3) mod 16.
  for (genvar gi = 0; gi < 16; gi++) begin : g_rotl3
    assign e_val[gi] = sum[(gi + 13) % 16];
  end

  assign cfail_inc = cfail_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    t_d         = t_q;
    hash_d      = hash_q;
    id_d        = id_q;
    exp_d       = exp_q;
    cfail_d     = cfail_q;
    fail_d      = fail_q;
    res_valid_d = 1'b0;
    res_ok_d    = res_ok_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          t_d     = in_time;
          hash_d  = in_hash;
          id_d    = student_id;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        exp_d       = e_val;
        res_valid_d = 1'b1;
        if (e_val == hash_q) begin
          h_d      = e_val;
          cfail_d  = 4'd0;
          res_ok_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cfail_d  = cfail_inc;
          res_ok_d = 1'b0;
          if (fail_q != {CNT_W{1'b1}}) begin
            fail_d = fail_q + 1'b1;
          end
          state_d = (cfail_inc == MAX_FAIL_C) ? ST_LOCKED : ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (unlock) begin
          h_d     = 16'd0;
          cfail_d = 4'd0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      h_q         <= 16'd0;
      t_q         <= 16'd0;
      hash_q      <= 16'd0;
      id_q        <= 16'd0;
      exp_q       <= 16'd0;
      cfail_q     <= 4'd0;
      fail_q      <= '0;
      res_valid_q <= 1'b0;
      res_ok_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      t_q         <= t_d;
      hash_q      <= hash_d;
      id_q        <= id_d;
      exp_q       <= exp_d;
      cfail_q     <= cfail_d;
      fail_q      <= fail_d;
      res_valid_q <= res_valid_d;
      res_ok_q    <= res_ok_d;
    end
  end

  assign in_ready      = (state_q == ST_IDLE);
  assign locked        = (state_q == ST_LOCKED);
  assign res_valid     = res_valid_q;
  assign res_ok        = res_ok_q;
  assign expected_hash = exp_q;
  assign fail_count    = fail_q;

endmodule

// File: tb/tb_hash_verifier.sv
module tb_hash_verifier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] student_id = 16'd0;
  logic        in_valid = 1'b0;
  logic [15:0] in_time = 16'd0;
  logic [15:0] in_hash = 16'd0;
  logic        in_ready;
  logic        unlock = 1'b0;
  logic        res_valid;
  logic        res_ok;
  logic [15:0] expected_hash;
  logic [7:0]  fail_count;
  logic        locked;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hash_verifier #(.MAX_FAIL(3), .CNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .student_id    (student_id),
    .in_valid      (in_valid),
    .in_time       (in_time),
    .in_hash       (in_hash),
    .in_ready      (in_ready),
    .unlock        (unlock),
    .res_valid     (res_valid),
    .res_ok        (res_ok),
    .expected_hash (expected_hash),
    .fail_count    (fail_count),
    .locked        (locked)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %-22s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Present a token, wait (bounded) for the handshake, then scramble the
  // payload during CHECK and return #1 after the result edge.
  task automatic send(input logic [15:0] t, input logic [15:0] hs);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_time  = t;
    in_hash  = hs;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_time  = ~t;
    in_hash  = ~hs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_ok", 32'(res_ok), 32'd0);
    chk("rst_exp", 32'(expected_hash), 32'd0);
    chk("rst_fail_count", 32'(fail_count), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic chain: id=3, (1,32) then (2,296)
    student_id = 16'd3;
    send(16'd1, 16'd32);
    chk("t1_res_valid", 32'(res_valid), 32'd1);
    chk("t1_res_ok", 32'(res_ok), 32'd1);
    chk("t1_exp", 32'(expected_hash), 32'd32);
    @(posedge clk); #1;
    chk("t1_res_valid_drop", 32'(res_valid), 32'd0);
    chk("t1_exp_held", 32'(expected_hash), 32'd32);
    send(16'd2, 16'd296);
    chk("t2_res_ok", 32'(res_ok), 32'd1);
    chk("t2_exp", 32'(expected_hash), 32'd296);

    // Add wrap-around
    do_reset();
    student_id = 16'hFFFF;
    send(16'd1, 16'd0);
    chk("wrap_res_ok", 32'(res_ok), 32'd1);
    chk("wrap_exp", 32'(expected_hash), 32'd0);

    // Rotate carries top bits into the bottom
    do_reset();
    student_id = 16'd0;
    send(16'hE000, 16'h0007);
    chk("rot_res_ok", 32'(res_ok), 32'd1);
    chk("rot_exp", 32'(expected_hash), 32'h0007);

    // Mismatch keeps the chain
    do_reset();
    student_id = 16'd3;
    send(16'd1, 16'd5);
    chk("mm_res_valid", 32'(res_valid), 32'd1);
    chk("mm_res_ok", 32'(res_ok), 32'd0);
    chk("mm_fail_count", 32'(fail_count), 32'd1);
    chk("mm_exp", 32'(expected_hash), 32'd32);
    send(16'd1, 16'd32);
    chk("mm_retry_ok", 32'(res_ok), 32'd1);
    chk("mm_retry_exp", 32'(expected_hash), 32'd32);

    // h=32 now; (1, bad) yields e = rotl3(33+3) = 288. Two misses must not
    // lock (consecutive count was cleared), the third must.
    send(16'd1, 16'd5);
    chk("lk1_exp", 32'(expected_hash), 32'd288);
    chk("lk1_locked", 32'(locked), 32'd0);
    send(16'd1, 16'd5);
    chk("lk2_locked", 32'(locked), 32'd0);
    chk("lk2_in_ready", 32'(in_ready), 32'd1);
    send(16'd1, 16'd5);
    chk("lk3_res_valid", 32'(res_valid), 32'd1);
    chk("lk3_locked", 32'(locked), 32'd1);
    chk("lk3_in_ready", 32'(in_ready), 32'd0);
    chk("lk3_fail_count", 32'(fail_count), 32'd4);
    chk("lk3_exp", 32'(expected_hash), 32'd288);

    // in_valid held while locked is not accepted
    @(negedge clk);
    in_valid = 1'b1;
    in_time  = 16'd1;
    in_hash  = 16'd32;
    repeat (3) @(negedge clk);
    chk("lk_hold_in_ready", 32'(in_ready), 32'd0);
    chk("lk_hold_res_valid", 32'(res_valid), 32'd0);
    chk("lk_hold_locked", 32'(locked), 32'd1);
    in_valid = 1'b0;

    // Unlock restarts the chain, keeps fail_count and expected_hash
    unlock = 1'b1;
    @(posedge clk); #1;
    unlock = 1'b0;
    chk("ul_in_ready", 32'(in_ready), 32'd1);
    chk("ul_locked", 32'(locked), 32'd0);
    chk("ul_fail_count", 32'(fail_count), 32'd4);
    chk("ul_exp_kept", 32'(expected_hash), 32'd288);
    send(16'd1, 16'd32);
    chk("ul_res_ok", 32'(res_ok), 32'd1);
    chk("ul_fail_kept", 32'(fail_count), 32'd4);

    // unlock in IDLE is ignored: chain continues from h=32
    @(negedge clk);
    unlock = 1'b1;
    @(negedge clk);
    unlock = 1'b0;
    send(16'd2, 16'd296);
    chk("idle_unlock_ign", 32'(res_ok), 32'd1);

    // Back-to-back with in_valid held and data changing during CHECK
    do_reset();
    student_id = 16'd3;
    begin
      logic [15:0] tv [4];
      logic [15:0] hv [4];
      tv = '{16'd1, 16'd2, 16'd3, 16'd4};
      hv = '{16'd32, 16'd296, 16'd2416, 16'd19384};
      @(negedge clk);
      in_valid = 1'b1;
      in_time  = tv[0];
      in_hash  = hv[0];
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("b2b%0d_ready", i), 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        chk($sformatf("b2b%0d_busy", i), 32'(in_ready), 32'd0);
        if (i < 3) begin
          in_time = tv[i+1];
          in_hash = hv[i+1];
        end else begin
          in_valid = 1'b0;
          in_time  = 16'hAAAA;
        end
        @(posedge clk); #1;
        chk($sformatf("b2b%0d_res_valid", i), 32'(res_valid), 32'd1);
        chk($sformatf("b2b%0d_res_ok", i), 32'(res_ok), 32'd1);
        chk($sformatf("b2b%0d_exp", i), 32'(expected_hash), 32'(hv[i]));
      end
    end

    // Async reset mid-CHECK after a mismatch has made outputs non-zero
    do_reset();
    student_id = 16'd3;
    send(16'd1, 16'd5);
    @(negedge clk);
    in_valid = 1'b1;
    in_time  = 16'd1;
    in_hash  = 16'd32;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("ar_in_check", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_res_valid", 32'(res_valid), 32'd0);
    chk("ar_res_ok", 32'(res_ok), 32'd0);
    chk("ar_exp", 32'(expected_hash), 32'd0);
    chk("ar_fail_count", 32'(fail_count), 32'd0);
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    chk("ar_locked", 32'(locked), 32'd0);
    @(posedge clk); #1;
    chk("ar_no_pulse", 32'(res_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(16'd1, 16'd32);
    chk("ar_after_res_ok", 32'(res_ok), 32'd1);
    chk("ar_after_exp", 32'(expected_hash), 32'd32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
